// File: rtl/seq_det_arb_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_arb_pkg
// Shared types for the multi-channel 1101 sequence detector / arbiter.
//   state_t : 3-bit Moore detector state, S0 (idle) .. S4 (1101 seen).
// No ports; imported by seq_det_step and seq_det_arbiter.
// -----------------------------------------------------------------------------
package seq_det_arb_pkg;

    typedef enum logic [2:0] {
        S0 = 3'b000,  // idle
        S1 = 3'b001,  // "1"
        S2 = 3'b010,  // "11"
        S3 = 3'b011,  // "110"
        S4 = 3'b100   // "1101" - detect
    } state_t;

    // True when a state is the Moore detect state.
    function automatic logic is_detect(input state_t s);
        return (s == S4);
    endfunction

endpackage

// File: rtl/seq_det_arb_if.sv
// -----------------------------------------------------------------------------
// seq_det_arb_if
// Requester / readback bundle for seq_det_arbiter.
//   req       [N_CH]  per-channel request, bit_in valid while high
//   bit_in    [N_CH]  per-channel serial data bit
//   ch_clr    [N_CH]  per-channel synchronous clear (context + counter)
//   gnt       [N_CH]  one-hot grant (combinational)
//   det_valid         registered one-cycle detect pulse
//   det_ch    [CH_W]  channel index qualifying det_valid
//   cnt_sel   [CH_W]  counter readback select
//   cnt_out   [CNT_W] detection count of channel cnt_sel (combinational)
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface seq_det_arb_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
);
    localparam int CH_W = $clog2(N_CH);

    logic [N_CH-1:0]  req;
    logic [N_CH-1:0]  bit_in;
    logic [N_CH-1:0]  ch_clr;
    logic [N_CH-1:0]  gnt;
    logic             det_valid;
    logic [CH_W-1:0]  det_ch;
    logic [CH_W-1:0]  cnt_sel;
    logic [CNT_W-1:0] cnt_out;

    modport master (
        output req, bit_in, ch_clr, cnt_sel,
        input  gnt, det_valid, det_ch, cnt_out
    );

    modport slave (
        input  req, bit_in, ch_clr, cnt_sel,
        output gnt, det_valid, det_ch, cnt_out
    );

endinterface

// File: rtl/seq_det_step.sv
// -----------------------------------------------------------------------------
// seq_det_step
// Combinational next-state function of the 1101 Moore detector. One instance
// is shared by all channels; the caller muxes in the granted channel's saved
// context and bit.
//   state      in   current detector state
//   bit_in     in   serial bit being consumed
//   next_state out  state after consuming bit_in
// Configuration macro: SEQ_DET_ARB_OVERLAP_EN
//   defined   -> overlapping detection   (S4 on 1 goes to S2)
//   undefined -> non-overlapping detection (S4 on 1 goes to S1)
// -----------------------------------------------------------------------------
module seq_det_step
    import seq_det_arb_pkg::*;
(
    input  state_t state,
    input  logic   bit_in,
    output state_t next_state
);

    always_comb begin
        // NOTE: default assigned first so every path drives next_state; no latch.
        next_state = S0;
        unique case (state)
            S0: next_state = bit_in ? S1 : S0;
            S1: next_state = bit_in ? S2 : S0;
            S2: next_state = bit_in ? S2 : S3;
            S3: next_state = bit_in ? S4 : S0;
`ifdef SEQ_DET_ARB_OVERLAP_EN
            // The trailing "1" of 1101 plus this "1" already form "11".
            S4: next_state = bit_in ? S2 : S0;
`else
            // The completed match is discarded; this "1" starts a new one.
            S4: next_state = bit_in ? S1 : S0;
`endif
            default: next_state = S0;
        endcase
    end

endmodule

// File: rtl/seq_det_arbiter.sv
// -----------------------------------------------------------------------------
// seq_det_arbiter
// N_CH serial requesters share one 1101 Moore detector. A round-robin arbiter
// grants one channel per cycle; the granted channel's saved detector context
// is advanced by the shared seq_det_step, all other contexts hold. Each
// channel keeps a saturating detection counter readable through cnt_sel.
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset
//   bus    seq_det_arb_if.slave (req/bit_in/ch_clr/gnt/det_valid/det_ch/
//          cnt_sel/cnt_out)
// Parameters N_CH and CNT_W must match those of the connected interface.
// Overlap behaviour is selected in seq_det_step by SEQ_DET_ARB_OVERLAP_EN.
// -----------------------------------------------------------------------------
module seq_det_arbiter
    import seq_det_arb_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
) (
    input  logic         clk,
    input  logic         reset,
    seq_det_arb_if.slave bus
);

    localparam int CH_W = $clog2(N_CH);

    state_t           ctx [N_CH];
    logic [CNT_W-1:0] cnt [N_CH];
    logic [CH_W-1:0]  ptr;
    logic             det_valid_q;
    logic [CH_W-1:0]  det_ch_q;

    logic             gnt_any;
    logic [CH_W-1:0]  gnt_idx;
    logic [N_CH-1:0]  gnt;
    logic [CH_W-1:0]  ptr_nxt;
    state_t           cur_state;
    state_t           nxt_state;
    logic             cur_bit;

    // Round-robin search: first requester at or above ptr, wrapping.
    always_comb begin
        logic [CH_W-1:0] idx;
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = CH_W'((int'(ptr) + k) % N_CH);
            if (!gnt_any && bus.req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
        if (gnt_any) gnt[gnt_idx] = 1'b1;
    end

    assign ptr_nxt = (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + CH_W'(1);

    // Shared detector works on the granted channel's saved context.
    assign cur_state = ctx[gnt_idx];
    assign cur_bit   = bus.bit_in[gnt_idx];

    seq_det_step u_step (
        .state      (cur_state),
        .bit_in     (cur_bit),
        .next_state (nxt_state)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the context bank and counters are flops, not RAM, so they
            // are cleared asynchronously along with the rest of the state.
            for (int i = 0; i < N_CH; i++) begin
                ctx[i] <= S0;
                cnt[i] <= '0;
            end
            ptr         <= '0;
            det_valid_q <= 1'b0;
            det_ch_q    <= '0;
        end else begin
            det_valid_q <= 1'b0;
            if (gnt_any) begin
                ptr          <= ptr_nxt;
                ctx[gnt_idx] <= nxt_state;
                if (is_detect(nxt_state) && !bus.ch_clr[gnt_idx]) begin
                    det_valid_q <= 1'b1;
                    det_ch_q    <= gnt_idx;
                    if (cnt[gnt_idx] != '1)
                        cnt[gnt_idx] <= cnt[gnt_idx] + CNT_W'(1);
                end
            end
            // NOTE: non-blocking updates to the same element resolve to the
            // last one scheduled, so a clear here overrides the advance above.
            for (int i = 0; i < N_CH; i++) begin
                if (bus.ch_clr[i]) begin
                    ctx[i] <= S0;
                    cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        bus.cnt_out = '0;
        if (int'(bus.cnt_sel) < N_CH) bus.cnt_out = cnt[bus.cnt_sel];
    end

    assign bus.gnt       = gnt;
    assign bus.det_valid = det_valid_q;
    assign bus.det_ch    = det_ch_q;

endmodule
